// File: rtl/imul_wb_queue_if.sv
// Issue, multiplier-result and writeback signals shared by the multiply writeback queue
// and the logic around it (scheduler, multiplier, writeback arbiter).
interface imul_wb_queue_if #(
  parameter int TAGW  = 9,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            issue_en;
  logic [TAGW-1:0] issue_tag;
  logic            issue_ready;
  logic [64:0]     mul_res;
  logic [5:0]      mul_flg;
  logic            wb_valid;
  logic [TAGW-1:0] wb_tag;
  logic [64:0]     wb_data;
  logic [5:0]      wb_flg;
  logic            wb_ack;
  logic [CW-1:0]   count;

  modport master (
    output issue_en, issue_tag, mul_res, mul_flg, wb_ack,
    input  issue_ready, wb_valid, wb_tag, wb_data, wb_flg, count
  );

  modport slave (
    input  issue_en, issue_tag, mul_res, mul_flg, wb_ack,
    output issue_ready, wb_valid, wb_tag, wb_data, wb_flg, count
  );
endinterface

// File: rtl/imul_wb_queue.sv
// Multiply writeback queue: follows issued tags through the multiplier latency, captures
// result and late flags into a FIFO, and presents entries in issue order with credit back.
module imul_wb_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          issue_en,
  input logic          issue_ready,
  input logic          capture,
  input logic          pop,
  input logic [CW-1:0] count
);
  a_issue_dropped: assert property (@(posedge clk) disable iff (rst) !(issue_en && !issue_ready))
    else $warning("issue_en seen while issue_ready low; op dropped");
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(capture && count == CW'(DEPTH)))
    else $error("capture into a full writeback queue");
  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH))
    else $error("writeback queue count out of range");
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0))
    else $error("pop from an empty writeback queue");
endmodule

module imul_wb_queue #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAGW  = 9
) (
  input logic           clk,
  input logic           rst,
  input logic           clkEn,
  imul_wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LAT + 1);
  localparam int OW = CW + IW + 1;

  logic [LAT-1:0]  pv_r;
  logic [TAGW-1:0] pt_r [LAT];
  logic [TAGW-1:0] q_tag_r  [DEPTH];
  logic [64:0]     q_data_r [DEPTH];
  logic [5:0]      q_flg_r  [DEPTH];
  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_r;
  logic [AW-1:0]   pend_idx_r;
  logic            pend_r;
  logic [CW-1:0]   count_r;

  logic [IW-1:0]   inflight_s;
  logic [OW-1:0]   occ_s;
  logic            issue_ready_s;
  logic            capture_s;
  logic            head_pend_s;
  logic            wb_valid_s;
  logic            pop_s;

  // Count ops still travelling through the multiplier.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_s = inflight_s + IW'(pv_r[i]);
    end
  end

  // Credit, capture and presentation decisions, all from registered state.
  always_comb begin
    occ_s         = OW'(count_r) + OW'(inflight_s);
    issue_ready_s = (occ_s < OW'(DEPTH));
    capture_s     = clkEn & pv_r[LAT-1];
    head_pend_s   = pend_r && (pend_idx_r == head_r);
    wb_valid_s    = (count_r != '0) && !head_pend_s;
    pop_s         = wb_valid_s & bus.wb_ack;
  end

  // Tag pipe mirrors the multiplier: advances only on clkEn.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_r <= '0;
      for (int i = 0; i < LAT; i++) pt_r[i] <= '0;
    end else if (clkEn) begin
      pv_r[0] <= bus.issue_en & issue_ready_s;
      pt_r[0] <= bus.issue_tag;
      for (int i = 1; i < LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pt_r[i] <= pt_r[i-1];
      end
    end
  end

  // Entry storage; flags trail the result by one clk regardless of clkEn.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_tag_r[i]  <= '0;
        q_data_r[i] <= '0;
        q_flg_r[i]  <= '0;
      end
    end else begin
      if (capture_s) begin
        q_tag_r[tail_r]  <= pt_r[LAT-1];
        q_data_r[tail_r] <= bus.mul_res;
      end
      if (pend_r) q_flg_r[pend_idx_r] <= bus.mul_flg;
    end
  end

  // FIFO pointers, occupancy and the single pending-flag slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= '0;
      tail_r     <= '0;
      pend_idx_r <= '0;
      pend_r     <= 1'b0;
      count_r    <= '0;
    end else begin
      if (capture_s) begin
        tail_r     <= tail_r + AW'(1);
        pend_idx_r <= tail_r;
      end
      if (pop_s) head_r <= head_r + AW'(1);
      pend_r <= capture_s;
      case ({capture_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_s;
  assign bus.wb_valid    = wb_valid_s;
  assign bus.wb_tag      = wb_valid_s ? q_tag_r[head_r]  : '0;
  assign bus.wb_data     = wb_valid_s ? q_data_r[head_r] : 65'h0;
  assign bus.wb_flg      = wb_valid_s ? q_flg_r[head_r]  : 6'h00;
  assign bus.count       = count_r;

  imul_wb_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (bus.issue_en),
    .issue_ready (issue_ready_s),
    .capture     (capture_s),
    .pop         (pop_s),
    .count       (count_r)
  );
endmodule

// File: tb/tb_imul_wb_queue.sv
// Scenario bench for imul_wb_queue: a small multiplier model feeds results, a scoreboard
// of issued ops is checked against every writeback pop.
module tb_imul_wb_queue;
  localparam int LAT = 2, DEPTH = 4, TAGW = 9;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [64:0]     data;
    logic [5:0]      flg;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, clkEn = 1'b1;
  imul_wb_queue_if #(.TAGW(TAGW), .DEPTH(DEPTH)) bus ();
  imul_wb_queue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t            sb[$];
  logic [64:0]     dat_tab [512];
  logic [5:0]      flg_tab [512];
  logic [TAGW-1:0] mp [LAT];
  int              errors = 0, checks = 0, delivered = 0;
  logic            prev_hold = 1'b0;
  exp_t            prev_out;

  // One clock: check pops/hold before the edge, update scoreboard and multiplier after it.
  task automatic tick();
    logic acc, pop;
    logic [5:0] new_flg;
    exp_t e;
    acc = clkEn && bus.issue_en && bus.issue_ready && !rst;
    pop = bus.wb_valid && bus.wb_ack && !rst;
    if (prev_hold && !rst) begin
      checks++;
      if ({bus.wb_valid, bus.wb_tag, bus.wb_data, bus.wb_flg} !== {1'b1, prev_out}) begin
        errors++;
        $display("FAIL hold: got v=%b %h/%h/%h expected v=1 %h/%h/%h", bus.wb_valid, bus.wb_tag,
                 bus.wb_data, bus.wb_flg, prev_out.tag, prev_out.data, prev_out.flg);
      end
    end
    if (pop) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_extra: got tag %h with nothing outstanding, expected no wb_valid", bus.wb_tag);
      end else begin
        e = sb[0];
        if ({bus.wb_tag, bus.wb_data, bus.wb_flg} !== e) begin
          errors++;
          $display("FAIL pop_order: got %h/%h/%h expected %h/%h/%h", bus.wb_tag, bus.wb_data,
                   bus.wb_flg, e.tag, e.data, e.flg);
        end
      end
    end
    prev_hold = bus.wb_valid && !bus.wb_ack && !rst;
    prev_out  = {bus.wb_tag, bus.wb_data, bus.wb_flg};
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (pop && sb.size() > 0) begin
        void'(sb.pop_front());
        delivered++;
      end
      if (acc) sb.push_back({bus.issue_tag, dat_tab[bus.issue_tag], flg_tab[bus.issue_tag]});
    end
    new_flg = flg_tab[mp[LAT-1]];
    if (clkEn) begin
      for (int i = LAT - 1; i > 0; i--) mp[i] = mp[i-1];
      mp[0] = bus.issue_tag;
    end
    bus.mul_flg = new_flg;
    bus.mul_res = dat_tab[mp[LAT-1]];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.wb_tag !== 9'h000) begin errors++; $display("FAIL reset_tag: got %h expected 000", bus.wb_tag); end
    checks++; if (bus.wb_data !== 65'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.wb_data); end
    checks++; if (bus.wb_flg !== 6'h00) begin errors++; $display("FAIL reset_flg: got %h expected 00", bus.wb_flg); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.issue_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic exp_v;
    clkEn = 1'b1; bus.wb_ack = 1'b1;
    bus.issue_en = 1'b1; bus.issue_tag = 9'h005;
    tick();
    bus.issue_en = 1'b0; bus.issue_tag = 9'h000;
    for (int k = 1; k <= 5; k++) begin
      exp_v = (k == 4);
      checks++;
      if (bus.wb_valid !== exp_v) begin errors++; $display("FAIL single_valid c%0d: got %b expected %b", k, bus.wb_valid, exp_v); end
      if (k == 4) begin
        checks++;
        if ({bus.wb_tag, bus.wb_data, bus.wb_flg} !== {9'h005, 65'h2A, 6'h03}) begin
          errors++; $display("FAIL single_out: got %h/%h/%h expected 005/2a/03", bus.wb_tag, bus.wb_data, bus.wb_flg);
        end
      end
      if (k == 5) begin
        checks++;
        if (bus.count !== 3'd0) begin errors++; $display("FAIL single_count: got %0d expected 0", bus.count); end
      end
      if (k < 5) tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.wb_ack = 1'b0; bus.issue_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.issue_ready); end
      bus.issue_tag = 9'(i);
      tick();
    end
    checks++;
    if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b expected 0", bus.issue_ready); end
    bus.issue_tag = 9'h01F;
    tick();
    bus.issue_en = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.count, bus.wb_valid, bus.wb_tag} !== {3'd4, 1'b1, 9'h001}) begin
      errors++; $display("FAIL b2b_full: got count=%0d v=%b tag=%h expected 4/1/001", bus.count, bus.wb_valid, bus.wb_tag);
    end
    tick(); tick();
    checks++;
    if ({bus.count, bus.issue_ready} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL b2b_stall: got count=%0d ready=%b expected 4/0", bus.count, bus.issue_ready);
    end
    bus.wb_ack = 1'b1;
    tick();
    checks++;
    if ({bus.count, bus.issue_ready} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL b2b_first_pop: got count=%0d ready=%b expected 3/1", bus.count, bus.issue_ready);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ({bus.count, bus.wb_valid, 32'(sb.size())} !== {3'd0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL b2b_drain: got count=%0d v=%b outstanding=%0d expected 0/0/0", bus.count, bus.wb_valid, sb.size());
    end
  endtask

  task automatic test_clken_stall();
    bus.wb_ack = 1'b1; clkEn = 1'b1;
    bus.issue_en = 1'b1; bus.issue_tag = 9'h033;
    tick();
    bus.issue_en = 1'b0; bus.issue_tag = 9'h000; clkEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.count !== 3'd0) begin errors++; $display("FAIL stall_hold_%0d: got count=%0d expected 0", i, bus.count); end
    end
    clkEn = 1'b1;
    tick();
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL stall_early: got count=%0d expected 0", bus.count); end
    tick();
    checks++;
    if ({bus.count, bus.wb_valid} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL stall_capture: got count=%0d v=%b expected 1/0", bus.count, bus.wb_valid);
    end
    clkEn = 1'b0;
    tick();
    checks++;
    if ({bus.wb_valid, bus.wb_tag, bus.wb_data, bus.wb_flg} !== {1'b1, 9'h033, dat_tab[9'h033], flg_tab[9'h033]}) begin
      errors++; $display("FAIL stall_flags: got v=%b %h/%h/%h expected 1 033/%h/%h", bus.wb_valid, bus.wb_tag,
                         bus.wb_data, bus.wb_flg, dat_tab[9'h033], flg_tab[9'h033]);
    end
    clkEn = 1'b1;
    tick();
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL stall_pop: got count=%0d expected 0", bus.count); end
  endtask

  task automatic test_capture_pop();
    bus.wb_ack = 1'b1;
    bus.issue_en = 1'b1; bus.issue_tag = 9'h0A1;
    tick();
    bus.issue_en = 1'b0;
    tick();
    bus.issue_en = 1'b1; bus.issue_tag = 9'h0B2;
    tick();
    bus.issue_en = 1'b0;
    tick();
    checks++;
    if ({bus.count, bus.wb_valid, bus.wb_tag} !== {3'd1, 1'b1, 9'h0A1}) begin
      errors++; $display("FAIL cp_pre: got count=%0d v=%b tag=%h expected 1/1/0a1", bus.count, bus.wb_valid, bus.wb_tag);
    end
    tick();
    checks++;
    if ({bus.count, bus.wb_valid} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL cp_pend: got count=%0d v=%b expected 1/0", bus.count, bus.wb_valid);
    end
    tick();
    checks++;
    if ({bus.wb_valid, bus.wb_tag} !== {1'b1, 9'h0B2}) begin
      errors++; $display("FAIL cp_new_head: got v=%b tag=%h expected 1/0b2", bus.wb_valid, bus.wb_tag);
    end
    tick();
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL cp_drain: got count=%0d expected 0", bus.count); end
  endtask

  task automatic test_reset_mid();
    bus.wb_ack = 1'b0;
    bus.issue_en = 1'b1; bus.issue_tag = 9'h060; tick();
    bus.issue_tag = 9'h061; tick();
    bus.issue_en = 1'b0; tick();
    bus.issue_en = 1'b1; bus.issue_tag = 9'h062; tick();
    bus.issue_en = 1'b0;
    checks++;
    if (bus.count !== 3'd2) begin errors++; $display("FAIL rm_pre: got count=%0d expected 2", bus.count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.count, bus.wb_valid, bus.issue_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rm_after: got count=%0d v=%b ready=%b expected 0/0/1", bus.count, bus.wb_valid, bus.issue_ready);
    end
    bus.wb_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.count, bus.wb_valid} !== {3'd0, 1'b0}) begin
        errors++; $display("FAIL rm_ghost_%0d: got count=%0d v=%b expected 0/0", i, bus.count, bus.wb_valid);
      end
    end
  endtask

  task automatic test_wrap();
    int issued, d0;
    issued = 0;
    d0 = delivered;
    for (int cyc = 0; cyc < 400 && !(issued == 10 && sb.size() == 0); cyc++) begin
      clkEn = ($urandom_range(0, 3) != 0);
      bus.wb_ack = 1'($urandom_range(0, 1));
      if (clkEn && issued < 10 && bus.issue_ready) begin
        bus.issue_en = 1'b1;
        bus.issue_tag = 9'(9'h100 + issued);
        issued++;
      end else begin
        bus.issue_en = 1'b0;
      end
      tick();
    end
    bus.issue_en = 1'b0; clkEn = 1'b1;
    checks++;
    if (issued != 10 || sb.size() != 0) begin
      errors++; $display("FAIL wrap_timeout: got issued=%0d outstanding=%0d expected 10/0", issued, sb.size());
    end
    checks++;
    if (delivered - d0 != 10) begin
      errors++; $display("FAIL wrap_delivered: got %0d expected 10", delivered - d0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      dat_tab[i] = {1'($urandom_range(0, 1)), $urandom, $urandom};
      flg_tab[i] = 6'($urandom_range(0, 63));
    end
    dat_tab[5] = 65'h2A;
    flg_tab[5] = 6'b000011;
    for (int i = 0; i < LAT; i++) mp[i] = '0;
    bus.issue_en = 1'b0; bus.issue_tag = '0; bus.wb_ack = 1'b0;
    bus.mul_res = dat_tab[0]; bus.mul_flg = flg_tab[0];
    test_reset();
    test_single();
    test_back_to_back();
    test_clken_stall();
    test_capture_pop();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
